// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM data-memory controller.
package mem_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLow  = 3'd1,
    StHigh = 3'd2,
    StWait = 3'd3,
    StDone = 3'd4
  } state_t;

  localparam logic [31:0] MEM_BASE_ADDR = 32'd1024;
  localparam int unsigned MEM_SRAM_AW   = 18;

  // Half-word select appended below the word index to form the SRAM address.
  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Access-time padding counter: loads WAIT_CYCLES-1, counts down, flags zero.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LoadVal = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LoadVal;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: 32-bit loads/stores as two 16-bit SRAM accesses plus fixed padding.
// Optional last-write forwarding is enabled by defining SRAM_LAST_WRITE_FWD_EN.
module sram_mem_controller
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = MEM_BASE_ADDR,
  parameter int unsigned SRAM_AW     = MEM_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_in,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned IW = SRAM_AW - 1;

  state_t state_q, state_d;

  logic               is_wr_q;
  logic [IW-1:0]      idx_q;
  logic [31:0]        data_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [15:0]        dq_out_q;

  logic [31:0] off;
  logic [IW-1:0] req_idx;
  logic req;
  logic cnt_load, cnt_dec, cnt_done;
  logic fwd_hit;
  logic [31:0] fwd_word;
  logic drive;

  assign off     = address - BASE_ADDR;
  assign req_idx = off[SRAM_AW:2];
  assign req     = wr_en | rd_en;

  logic unused_off;
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

`ifdef SRAM_LAST_WRITE_FWD_EN
  logic          fwd_valid_q;
  logic [IW-1:0] fwd_idx_q;
  logic [31:0]   fwd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_data_q  <= '0;
    end else if ((state_q == StDone) && is_wr_q) begin
      fwd_valid_q <= 1'b1;
      fwd_idx_q   <= idx_q;
      fwd_data_q  <= data_q;
    end
  end

  assign fwd_hit   = (state_q == StIdle) && rd_en && !wr_en && fwd_valid_q &&
                     (fwd_idx_q == req_idx);
  assign fwd_word  = fwd_data_q;
  assign read_data = fwd_hit ? fwd_data_q : read_data_q;
`else
  assign fwd_hit   = 1'b0;
  assign fwd_word  = '0;
  assign read_data = read_data_q;
`endif

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .dec (cnt_dec),
    .done(cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = ~req | fwd_hit;
        if (req && !fwd_hit) state_d = StLow;
      end
      StLow:  state_d = StHigh;
      StHigh: begin
        state_d  = StWait;
        cnt_load = 1'b1;
      end
      StWait: begin
        if (cnt_done) state_d = StDone;
        else          cnt_dec = 1'b1;
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      is_wr_q     <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (req && !fwd_hit) begin
            // A simultaneous read and write is treated as a write.
            is_wr_q     <= wr_en;
            idx_q       <= req_idx;
            data_q      <= write_data;
            sram_addr_q <= {req_idx, LO};
            dq_out_q    <= write_data[15:0];
          end else if (fwd_hit) begin
            read_data_q <= fwd_word;
          end
        end
        StLow: begin
          sram_addr_q <= {idx_q, HI};
          dq_out_q    <= data_q[31:16];
          if (!is_wr_q) data_q[15:0] <= sram_dq_in;
        end
        StHigh: begin
          if (!is_wr_q) read_data_q <= {sram_dq_in, data_q[15:0]};
        end
        default: ;
      endcase
    end
  end

  // Reset gates the strobe immediately so an interrupted write never lands its next half.
  assign drive       = is_wr_q && ((state_q == StLow) || (state_q == StHigh)) && !rst;
  assign sram_we_n   = ~drive;
  assign sram_dq_oe  = drive;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed scenarios plus random accesses vs a word-level model.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in, sram_dq_out;
  logic        sram_dq_oe, sram_we_n;

  int errors = 0;
  int checks = 0;

  logic [15:0] sram [0:262143];
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] ref_rd;
  logic        lw_valid;
  logic [16:0] lw_idx;

  logic [17:0] tr_addr [16];
  logic        tr_we   [16];
  logic        tr_oe   [16];
  logic [15:0] tr_dq   [16];

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_in (sram_dq_in),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  // SRAM model: asynchronous read, write taken mid-cycle while we_n is low.
  assign sram_dq_in = sram[sram_addr];
  always @(negedge clk) if (!sram_we_n) sram[sram_addr] = sram_dq_out;

  function automatic logic [16:0] widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - 32'd1024) >> 2;
    return o[16:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [16:0] i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  function automatic int exp_stall(input logic w, input logic r, input logic [31:0] a);
`ifdef SRAM_LAST_WRITE_FWD_EN
    if (r && !w && lw_valid && (lw_idx == widx(a))) return 0;
`endif
    return 6;
  endfunction

  task automatic note_write(input logic [31:0] a, input logic [31:0] d);
    ref_mem[widx(a)] = d;
    lw_valid = 1'b1;
    lw_idx   = widx(a);
  endtask

  // Presents a request and waits for ready; returns at the sample point of the ready cycle.
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic drop, output int stall);
    stall = 0;
    wr_en = w; rd_en = r; address = a; write_data = d;
    #1;
    while (!ready && stall < 40) begin
      if (stall < 16) begin
        tr_addr[stall] = sram_addr;
        tr_we[stall]   = sram_we_n;
        tr_oe[stall]   = sram_dq_oe;
        tr_dq[stall]   = sram_dq_out;
      end
      if (drop && stall == 1) begin
        wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
      end
      stall++;
      @(posedge clk); #2;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got=%h exp=0", read_data); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_sram_addr got=%h exp=0", sram_addr); end
    checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL reset_dq_out got=%h exp=0", sram_dq_out); end
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL reset_bus got we_n=%b oe=%b exp we_n=1 oe=0", sram_we_n, sram_dq_oe);
    end
    ref_rd = 32'h0; lw_valid = 1'b0; lw_idx = '0;
  endtask

  task automatic test_write_read();
    int st, es;
    next_cycle();
    es = exp_stall(1'b1, 1'b0, 32'd1032);
    access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0, st);
    checks++; if (st !== es) begin errors++; $display("FAIL write_stall got=%0d exp=%0d", st, es); end
    checks++; if (tr_addr[1] !== 18'd4 || tr_dq[1] !== 16'hBEEF || tr_we[1] !== 1'b0 || tr_oe[1] !== 1'b1) begin
      errors++; $display("FAIL write_low got addr=%0d dq=%h we_n=%b oe=%b exp addr=4 dq=beef we_n=0 oe=1",
                         tr_addr[1], tr_dq[1], tr_we[1], tr_oe[1]);
    end
    checks++; if (tr_addr[2] !== 18'd5 || tr_dq[2] !== 16'hDEAD || tr_we[2] !== 1'b0) begin
      errors++; $display("FAIL write_high got addr=%0d dq=%h we_n=%b exp addr=5 dq=dead we_n=0",
                         tr_addr[2], tr_dq[2], tr_we[2]);
    end
    checks++; if (tr_we[3] !== 1'b1 || tr_oe[3] !== 1'b0 || tr_addr[3] !== 18'd5) begin
      errors++; $display("FAIL write_wait got we_n=%b oe=%b addr=%0d exp we_n=1 oe=0 addr=5",
                         tr_we[3], tr_oe[3], tr_addr[3]);
    end
    note_write(32'd1032, 32'hDEADBEEF);
    next_cycle();
    es = exp_stall(1'b0, 1'b1, 32'd1032);
    access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, st);
    ref_rd = ref_word(widx(32'd1032));
    checks++; if (st !== es) begin errors++; $display("FAIL read_stall got=%0d exp=%0d", st, es); end
    checks++; if (read_data !== ref_rd) begin errors++; $display("FAIL read_data got=%h exp=%h", read_data, ref_rd); end
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_both();
    int st;
    next_cycle();
    access(1'b1, 1'b1, 32'd1040, 32'h12345678, 1'b0, st);
    note_write(32'd1040, 32'h12345678);
    checks++; if (st !== 6) begin errors++; $display("FAIL both_stall got=%0d exp=6", st); end
    checks++; if (sram[8] !== 16'h5678 || sram[9] !== 16'h1234) begin
      errors++; $display("FAIL both_mem got w8=%h w9=%h exp w8=5678 w9=1234", sram[8], sram[9]);
    end
    checks++; if (read_data !== ref_rd) begin errors++; $display("FAIL both_read_data got=%h exp=%h", read_data, ref_rd); end
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, old;
    d = $urandom;
    old = ref_word(widx(32'd1200));
    next_cycle();
    wr_en = 1'b1; address = 32'd1200; write_data = d;
    next_cycle();                                   // LOW
    next_cycle();                                   // HIGH
    rst = 1'b1; wr_en = 1'b0; #1;
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL rst_high_bus got we_n=%b oe=%b exp we_n=1 oe=0", sram_we_n, sram_dq_oe);
    end
    next_cycle();
    rst = 1'b0; #1;
    checks++; if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_state got ready=%b we_n=%b oe=%b rd=%h exp ready=1 we_n=1 oe=0 rd=0",
                         ready, sram_we_n, sram_dq_oe, read_data);
    end
    checks++; if (sram[89] !== old[31:16]) begin
      errors++; $display("FAIL rst_mid_high_word got=%h exp=%h", sram[89], old[31:16]);
    end
    ref_mem[widx(32'd1200)] = {old[31:16], d[15:0]};
    ref_rd = 32'h0; lw_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int st1, st2;
    next_cycle();
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, st1);
    ref_rd = ref_word(widx(32'd1024));
    checks++; if (read_data !== ref_rd) begin errors++; $display("FAIL b2b_first got=%h exp=%h", read_data, ref_rd); end
    next_cycle();
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, st2);
    ref_rd = ref_word(widx(32'd1028));
    checks++; if (read_data !== ref_rd) begin errors++; $display("FAIL b2b_second got=%h exp=%h", read_data, ref_rd); end
    checks++; if (st1 + st2 !== 12) begin errors++; $display("FAIL b2b_stalls got=%0d exp=12", st1 + st2); end
    next_cycle();
    rd_en = 1'b0;
  endtask

  task automatic test_random();
    int st, es, op;
    logic [31:0] a, d;
    logic drop;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      a = ($urandom_range(0, 4) == 0) ? $urandom
                                       : 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d = $urandom;
      drop = 1'($urandom_range(0, 1));
      es = exp_stall(op != 1, op != 0, a);
      next_cycle();
      access(op != 1, op != 0, a, d, drop && (es != 0), st);
      if (op == 1) ref_rd = ref_word(widx(a));
      else note_write(a, d);
      checks++; if (st !== es) begin errors++; $display("FAIL rand_stall[%0d] got=%0d exp=%0d", i, st, es); end
      checks++; if (read_data !== ref_rd) begin
        errors++; $display("FAIL rand_read_data[%0d] got=%h exp=%h", i, read_data, ref_rd);
      end
      if ($urandom_range(0, 1) == 1) begin
        next_cycle();
        wr_en = 1'b0; rd_en = 1'b0;
      end
    end
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

`ifdef SRAM_LAST_WRITE_FWD_EN
  task automatic test_forward();
    int st;
    next_cycle();
    access(1'b1, 1'b0, 32'd1100, 32'hCAFEF00D, 1'b0, st);
    note_write(32'd1100, 32'hCAFEF00D);
    next_cycle();
    access(1'b0, 1'b1, 32'd1100, 32'h0, 1'b0, st);
    ref_rd = ref_word(widx(32'd1100));
    checks++; if (st !== 0) begin errors++; $display("FAIL fwd_stall got=%0d exp=0", st); end
    checks++; if (read_data !== 32'hCAFEF00D) begin errors++; $display("FAIL fwd_data got=%h exp=cafef00d", read_data); end
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL fwd_bus got we_n=%b oe=%b exp we_n=1 oe=0", sram_we_n, sram_dq_oe);
    end
    next_cycle();
    rd_en = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
    test_reset();
    test_write_read();
    test_both();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef SRAM_LAST_WRITE_FWD_EN
    test_forward();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
